// File: rtl/key_schedule_ctrl.sv
// ---------------------------------------------------------------------------
// key_schedule_ctrl
//
// Sequences an RC5-style key expansion against an external key byte store
// and an external S word memory, both read asynchronously in the same cycle.
//
// The sequence is:
//   LOAD  : pack the key bytes, highest address first, into the L words.
//   INIT  : fill S with the magic progression P, P+Q, P+2Q, ...
//   MIX_S : S[i] <= rotl(S[i] + A + B, 3), A takes the new S[i].
//   MIX_L : L[j] <= rotl(L[j] + A + B, A + B), B takes the new L[j].
//           MIX_S/MIX_L alternate for 3*max(T, C) iterations.
//   DONE  : one-cycle completion pulse, then back to IDLE.
//
// Parameters
//   W : word width in bits (power of two, 8..64)
//   B : key length in bytes
//   T : number of S words, 2*(rounds+1)
//   C : number of L words, max(1, ceil(B*8/W))
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     request a schedule; only looked at while IDLE
//   busy      high from the cycle after start is taken up to and incl. DONE
//   done      one-cycle pulse in the DONE state
//   key_addr  key byte address (LOAD only, 0 otherwise)
//   key_byte  key byte at key_addr, same cycle
//   s_addr    S memory address (INIT/MIX_S only, 0 otherwise)
//   s_we      S memory write enable, one word per cycle
//   s_wdata   S memory write data (0 when not writing)
//   s_rdata   S memory word at s_addr, same cycle
// ---------------------------------------------------------------------------
module key_schedule_ctrl #(
    parameter int W = 32,
    parameter int B = 16,
    parameter int T = 26,
    parameter int C = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(B)-1:0] key_addr,
    input  logic [7:0]           key_byte,
    output logic [$clog2(T)-1:0] s_addr,
    output logic                 s_we,
    output logic [W-1:0]         s_wdata,
    input  logic [W-1:0]         s_rdata
);

    localparam int KAW  = $clog2(B);
    localparam int SAW  = $clog2(T);
    localparam int CW   = (C > 1) ? $clog2(C) : 1;
    localparam int RW   = $clog2(W);
    localparam int BSH  = $clog2(W / 8);
    localparam int ITER = 3 * ((T > C) ? T : C);
    localparam int KW   = $clog2(ITER + 1);

    // The magic constants are the leading bits of (e-2) and (phi-1) forced
    // odd; deriving them from the 64-bit values covers every legal W.
    localparam logic [63:0]  P64 = 64'hB7E1_5162_8AED_2A6B;
    localparam logic [63:0]  Q64 = 64'h9E37_79B9_7F4A_7C15;
    localparam logic [W-1:0] P_W = W'(P64 >> (64 - W)) | W'(1);
    localparam logic [W-1:0] Q_W = W'(Q64 >> (64 - W)) | W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_INIT  = 3'd2,
        ST_MIX_S = 3'd3,
        ST_MIX_L = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Rotate left by amt; the upper half of the doubled word is the result.
    function automatic logic [W-1:0] rotl(input logic [W-1:0] x,
                                          input logic [RW-1:0] amt);
        logic [2*W-1:0] dbl;
        dbl = {x, x} << amt;
        return dbl[2*W-1:W];
    endfunction

    state_t          state_q, state_d;
    logic [KAW-1:0]  n_q, n_d;
    logic [SAW-1:0]  i_q, i_d;
    logic [CW-1:0]   j_q, j_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [W-1:0]    l_q [C];
    logic [W-1:0]    l_d [C];

    logic [W-1:0]    ab_sum_s;
    logic [W-1:0]    mix_s_val_s;
    logic [W-1:0]    mix_l_val_s;
    logic [CW-1:0]   l_idx_s;

    assign ab_sum_s    = a_q + b_q;
    assign mix_s_val_s = rotl(s_rdata + ab_sum_s, RW'(3));
    assign mix_l_val_s = rotl(l_q[j_q] + ab_sum_s, ab_sum_s[RW-1:0]);
    // Byte n lands in word n / (W/8); W/8 is a power of two so a shift does.
    assign l_idx_s     = CW'(n_q >> BSH);

    // Next-state, datapath updates and output decode.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        l_d      = l_q;
        busy     = 1'b0;
        done     = 1'b0;
        key_addr = KAW'(0);
        s_addr   = SAW'(0);
        s_we     = 1'b0;
        s_wdata  = W'(0);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    n_d     = KAW'(B - 1);
                    i_d     = SAW'(0);
                    j_d     = CW'(0);
                    k_d     = KW'(0);
                    a_d     = W'(0);
                    b_d     = W'(0);
                    sum_d   = P_W;
                    for (int m = 0; m < C; m++) begin
                        l_d[m] = W'(0);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LOAD: begin
                busy         = 1'b1;
                key_addr     = n_q;
                l_d[l_idx_s] = (l_q[l_idx_s] << 4'd8) + W'(key_byte);
                if (n_q == KAW'(0)) begin
                    state_d = ST_INIT;
                end else begin
                    n_d = n_q - KAW'(1);
                end
            end

            ST_INIT: begin
                busy    = 1'b1;
                s_addr  = i_q;
                s_we    = 1'b1;
                s_wdata = sum_q;
                // Running sum replaces P + i*Q, so no multiplier is needed.
                sum_d   = sum_q + Q_W;
                if (i_q == SAW'(T - 1)) begin
                    i_d     = SAW'(0);
                    state_d = ST_MIX_S;
                end else begin
                    i_d = i_q + SAW'(1);
                end
            end

            ST_MIX_S: begin
                busy    = 1'b1;
                s_addr  = i_q;
                s_we    = 1'b1;
                s_wdata = mix_s_val_s;
                a_d     = mix_s_val_s;
                state_d = ST_MIX_L;
            end

            ST_MIX_L: begin
                busy     = 1'b1;
                l_d[j_q] = mix_l_val_s;
                b_d      = mix_l_val_s;
                k_d      = k_q + KW'(1);
                if (i_q == SAW'(T - 1)) begin
                    i_d = SAW'(0);
                end else begin
                    i_d = i_q + SAW'(1);
                end
                if (j_q == CW'(C - 1)) begin
                    j_d = CW'(0);
                end else begin
                    j_d = j_q + CW'(1);
                end
                if (k_q == KW'(ITER - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MIX_S;
                end
            end

            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            n_q     <= KAW'(0);
            i_q     <= SAW'(0);
            j_q     <= CW'(0);
            k_q     <= KW'(0);
            a_q     <= W'(0);
            b_q     <= W'(0);
            sum_q   <= W'(0);
            for (int m = 0; m < C; m++) begin
                l_q[m] <= W'(0);
            end
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            for (int m = 0; m < C; m++) begin
                l_q[m] <= l_d[m];
            end
        end
    end

endmodule

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 Parameter W, default 32, word width in bits (power of 2).
REQ-002 Parameter B, default 16, key length in bytes.
REQ-003 Parameter T, default 26, S-table words, 2*(rounds+1).
REQ-004 Parameter C, default 4, L words, max(1, ceil(B*8/W)).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  request one full key schedule; sampled only in IDLE.
REQ-008 busy  output  1  high from cycle after start accepted through DONE.
REQ-009 done  output  1  one-cycle pulse when S table complete.
REQ-010 key_addr  output  clog2(B)  key byte address.
REQ-011 key_byte  input  8  key byte at key_addr, asynchronous read, same cycle.
REQ-012 s_addr  output  clog2(T)  S memory address.
REQ-013 s_we  output  1  S memory write enable, one word per cycle.
REQ-014 s_wdata  output  W  S memory write data.
REQ-015 s_rdata  input  W  S memory word at s_addr, asynchronous read, same cycle.

Function
REQ-016 FSM states IDLE, LOAD, INIT, MIX_S, MIX_L, DONE; IDLE->LOAD on start; LOAD->INIT after B cycles; INIT->MIX_S after T cycles; MIX_S->MIX_L always; MIX_L->MIX_S until 3*max(T,C) iterations, then DONE; DONE->IDLE after one cycle.
REQ-017 On start acceptance: internal L[0..C-1], A, B, counters i, j, k cleared to 0.
REQ-018 LOAD: byte index n from B-1 down to 0, one per cycle; key_addr=n; L[n/(W/8)] <= (L[n/(W/8)] << 8) + key_byte, truncated to W bits; s_we=0.
REQ-019 INIT: index i 0..T-1; s_addr=i, s_we=1, s_wdata = P + i*Q mod 2^W (P=0xB7E15163, Q=0x9E3779B9 for W=32); running-sum register, no multiplier.
REQ-020 MIX_S: s_addr=i; s_wdata = rotl(s_rdata + A + B, 3); s_we=1; A <= s_wdata.
REQ-021 MIX_L: s_we=0; X = L[j] + A + B; L[j] <= rotl(X, (A+B) mod W); B <= same value; then i <= (i+1) mod T, j <= (j+1) mod C, k <= k+1.
REQ-022 All additions modulo 2^W; rotate amount uses low clog2(W) bits of A+B.
REQ-023 Latency: done high exactly B + T + 6*max(T,C) + 1 cycles after the edge that samples start (199 for defaults).
REQ-024 start while busy ignored; no restart, no queueing.
REQ-025 start asserted in the DONE cycle ignored; start held high re-triggers on first IDLE cycle.
REQ-026 s_we low in IDLE, LOAD, MIX_L, DONE; s_addr, key_addr, s_wdata driven 0 when not used.
REQ-027 i wraps T-1->0 and j wraps C-1->0 independently during MIX.

Reset
REQ-028 rst asserted: state IDLE, busy=0, done=0, s_we=0, key_addr=0, s_addr=0, s_wdata=0, L/A/B/counters=0, immediately without clock.
REQ-029 rst mid-operation aborts schedule; S memory content left partial; next start begins a full schedule from LOAD.

Verification
REQ-030 Key bytes 0x00..0x0F, start pulse -> L[0]=0x03020100, L[3]=0x0F0E0D0C at end of LOAD; INIT writes S[0]=0xB7E15163, S[1]=0x5618CB1C, S[25]=0x2B4C3474.
REQ-031 Same key -> first MIX_S writes S[0]=0xBF0A8B1D; first MIX_L sets B=0xB8419183; second MIX_S writes S[1]=0x6B273DE6.
REQ-032 Any key, defaults -> done pulses exactly 199 cycles after start sampled, width 1; busy high for cycles 1..199; exactly 26+78 S writes counted.
REQ-033 start re-pulsed at cycles 5, 50, 150 of a run -> ignored; done timing and S writes identical to single-start run.
REQ-034 rst asserted at cycle 100 of MIX -> outputs at reset values same cycle; new start -> full run, final S table matches golden model of uninterrupted run.
REQ-035 Back-to-back: start held high continuously -> second run begins cycle after DONE, produces identical S table.
